typewriter_out: RTL and testbench

//  Output peripheral at the far end of the G-15 slow-out path. Accepts 5-bit output codes

---
 rtl/g15_io_pkg.sv | 66 ++++++
 rtl/io_code_fifo.sv | 62 ++++++
 rtl/typewriter_out.sv | 155 +++++++++++++++
 tb/tb_typewriter_out.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/g15_io_pkg.sv
// Purpose: shared types for the G-15 slow-out typewriter path (output codes, FSM states, ASCII map).
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package g15_io_pkg;

  // 5-bit slow-out codes as carried on OB5..OB1; 8..15 are unassigned.
  typedef enum logic [4:0] {
    SPACE  = 5'd0,
    MINUS  = 5'd1,
    CR     = 5'd2,
    TAB    = 5'd3,
    STOP   = 5'd4,
    RELOAD = 5'd5,
    PERIOD = 5'd6,
    WAIT   = 5'd7,
    DIG0   = 5'd16,
    DIG1   = 5'd17,
    DIG2   = 5'd18,
    DIG3   = 5'd19,
    DIG4   = 5'd20,
    DIG5   = 5'd21,
    DIG6   = 5'd22,
    DIG7   = 5'd23,
    DIG8   = 5'd24,
    DIG9   = 5'd25,
    U      = 5'd26,
    V      = 5'd27,
    W      = 5'd28,
    X      = 5'd29,
    Y      = 5'd30,
    Z      = 5'd31
  } g15_out_code_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EMIT    = 3'd1,
    EMIT_CR = 3'd2,
    EMIT_LF = 3'd3,
    PACE    = 3'd4
  } tw_state_e;

  // Returns {valid, byte}. CR maps to its first byte (0Dh); the LF is
  // generated by the FSM. Control codes and unassigned codes are invalid.
  function automatic logic [8:0] to_ascii(input logic [4:0] code);
    logic [7:0] c8;
    logic [8:0] res;
    c8  = {3'b000, code};
    res = 9'h000;
    if (code inside {[5'd16:5'd25]}) begin
      res = {1'b1, c8 + 8'h20};        // 16 -> '0' (30h)
    end else if (code inside {[5'd26:5'd31]}) begin
      res = {1'b1, c8 + 8'h5B};        // 26 -> 'u' (75h)
    end else begin
      case (code)
        5'd0:    res = {1'b1, 8'h20};
        5'd1:    res = {1'b1, 8'h2D};
        5'd2:    res = {1'b1, 8'h0D};
        5'd3:    res = {1'b1, 8'h09};
        5'd6:    res = {1'b1, 8'h2E};
        default: res = 9'h000;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/io_code_fifo.sv
// Purpose: small synchronous FIFO for slow-out codes, head word visible combinationally.
// Latency: a pushed word is visible on pop_data the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports: clk, rst_n (async active-low); push/push_data in; pop in, pop_data out;
//        full/empty/count status, all from registered occupancy.
module io_code_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push & (~full | do_pop);

  // Storage needs no reset: only slots behind a valid pointer are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/typewriter_out.sv
// Purpose: G-15 slow-out typewriter: buffers 5-bit codes, decodes to ASCII, paces output.
// Latency: strobe at cycle t -> FIFO pop at t+1 -> tx_valid at t+2; CHAR_CYCLES idle clocks after each byte.
// Backpressure: tx_data held until tx_ready; SW_SA low while the code FIFO is full, strobes then dropped (ERR).
// Ports: CLOCK, rst_n (async active-low); SLOW_OUT, OB1..OB5, TYPE_STROBE capture side;
//        SW_SA device ready, STOP_DONE pulse, ERR sticky; tx_data/tx_valid/tx_ready host side.
module typewriter_out
  import g15_io_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int CHAR_CYCLES = 16
) (
  input  logic       CLOCK,
  input  logic       rst_n,
  input  logic       SLOW_OUT,
  input  logic       OB1,
  input  logic       OB2,
  input  logic       OB3,
  input  logic       OB4,
  input  logic       OB5,
  input  logic       TYPE_STROBE,
  output logic       SW_SA,
  output logic       STOP_DONE,
  output logic       ERR,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int PW = $clog2(CHAR_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PACE_LOAD = PW'(CHAR_CYCLES - 1);

  logic [4:0]    in_code;
  logic [4:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          overflow;

  tw_state_e     state_q, state_d;
  logic [PW-1:0] pace_q, pace_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          stop_q, stop_d;
  logic          err_q;
  logic          undef_hit;
  logic [8:0]    head_ascii;
  g15_out_code_e head_code;

  assign in_code  = {OB5, OB4, OB3, OB2, OB1};
  assign push     = TYPE_STROBE & SLOW_OUT & (~fifo_full | pop);
  assign overflow = TYPE_STROBE & SLOW_OUT & fifo_full & ~pop;

  io_code_fifo #(
    .WIDTH (5),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_code),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_code  = g15_out_code_e'(fifo_dout);
  assign head_ascii = to_ascii(fifo_dout);

  always_comb begin
    state_d   = state_q;
    pace_d    = pace_q;
    tx_data_d = tx_data_q;
    stop_d    = 1'b0;
    undef_hit = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head_code)
            CR: begin
              state_d   = EMIT_CR;
              tx_data_d = 8'h0D;
            end
            WAIT: begin
              state_d = PACE;
              pace_d  = PACE_LOAD;
            end
            STOP:   stop_d = 1'b1;
            RELOAD: ;
            default: begin
              if (head_ascii[8]) begin
                state_d   = EMIT;
                tx_data_d = head_ascii[7:0];
              end else begin
                undef_hit = 1'b1;
              end
            end
          endcase
        end
      end
      EMIT: begin
        if (tx_ready) begin
          state_d = PACE;
          pace_d  = PACE_LOAD;
        end
      end
      EMIT_CR: begin
        if (tx_ready) begin
          state_d   = EMIT_LF;
          tx_data_d = 8'h0A;
        end
      end
      EMIT_LF: begin
        if (tx_ready) begin
          state_d = PACE;
          pace_d  = PACE_LOAD;
        end
      end
      PACE: begin
        if (pace_q == '0) state_d = IDLE;
        else              pace_d  = pace_q - PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pace_q    <= '0;
      tx_data_q <= 8'h00;
      stop_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pace_q    <= pace_d;
      tx_data_q <= tx_data_d;
      stop_q    <= stop_d;
      err_q     <= err_q | overflow | undef_hit;
    end
  end

  // tx_valid is decoded from the state register so an async reset drops it at once.
  assign tx_valid  = (state_q == EMIT) || (state_q == EMIT_CR) || (state_q == EMIT_LF);
  assign tx_data   = tx_data_q;
  assign STOP_DONE = stop_q;
  assign ERR       = err_q;
  assign SW_SA     = (fifo_count != CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_typewriter_out.sv
module tb_typewriter_out;

  localparam int CC = 16;

  logic       CLOCK = 1'b0;
  logic       rst_n;
  logic       SLOW_OUT;
  logic [4:0] ob;
  logic       TYPE_STROBE;
  logic       SW_SA;
  logic       STOP_DONE;
  logic       ERR;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  always #5 CLOCK = ~CLOCK;

  typewriter_out #(.FIFO_DEPTH(4), .CHAR_CYCLES(CC)) dut (
    .CLOCK       (CLOCK),
    .rst_n       (rst_n),
    .SLOW_OUT    (SLOW_OUT),
    .OB1         (ob[0]),
    .OB2         (ob[1]),
    .OB3         (ob[2]),
    .OB4         (ob[3]),
    .OB5         (ob[4]),
    .TYPE_STROBE (TYPE_STROBE),
    .SW_SA       (SW_SA),
    .STOP_DONE   (STOP_DONE),
    .ERR         (ERR),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor (negedge sampling) ----------------
  logic [7:0] got_q [$];
  int         got_cyc [$];
  int         cyc       = 0;
  int         stop_cnt  = 0;
  int         stop_dbl  = 0;
  int         stab_bad  = 0;
  logic       p_hold    = 1'b0;
  logic [7:0] p_data    = 8'h00;
  logic       p_stop    = 1'b0;

  initial begin
    forever begin
      @(negedge CLOCK);
      cyc++;
      if (!rst_n) begin
        p_hold = 1'b0;
        p_stop = 1'b0;
      end else begin
        // A byte offered but not taken must stay offered, unchanged.
        if (p_hold && (!tx_valid || tx_data !== p_data)) stab_bad++;
        if (tx_valid && tx_ready) begin
          got_q.push_back(tx_data);
          got_cyc.push_back(cyc);
        end
        if (STOP_DONE) begin
          stop_cnt++;
          if (p_stop) stop_dbl++;
        end
        p_hold = tx_valid && !tx_ready;
        p_data = tx_data;
        p_stop = STOP_DONE;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_q [$];
  int         rd_idx     = 0;
  int         exp_stops  = 0;
  bit         rand_ready = 1'b0;

  function automatic int ref_decode(input int code, output logic [7:0] b0, output logic [7:0] b1);
    b0 = 8'h00;
    b1 = 8'h00;
    if (code >= 16 && code <= 25) begin b0 = 8'(48 + code - 16);  return 1; end
    if (code >= 26 && code <= 31) begin b0 = 8'(117 + code - 26); return 1; end
    case (code)
      0: begin b0 = 8'h20; return 1; end
      1: begin b0 = 8'h2D; return 1; end
      2: begin b0 = 8'h0D; b1 = 8'h0A; return 2; end
      3: begin b0 = 8'h09; return 1; end
      6: begin b0 = 8'h2E; return 1; end
      default: return 0;
    endcase
  endfunction

  task automatic model_push(input int code);
    logic [7:0] b0, b1;
    int n;
    n = ref_decode(code, b0, b1);
    if (n >= 1) exp_q.push_back(b0);
    if (n == 2) exp_q.push_back(b1);
    if (code == 4) exp_stops++;
  endtask

  // ---------------- drivers (posedge + 1) ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
      if (rand_ready) tx_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic drive_strobe(input int code);
    ob          = 5'(code);
    TYPE_STROBE = 1'b1;
    step(1);
  endtask

  task automatic send(input int code);
    drive_strobe(code);
    TYPE_STROBE = 1'b0;
    if (SLOW_OUT) model_push(code);
  endtask

  task automatic wait_sa();
    int k;
    k = 0;
    while (!SW_SA && k < 2000) begin step(1); k++; end
    if (!SW_SA) check_eq("sw_sa_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    int k;
    int n;
    k = 0;
    n = exp_q.size();
    while (got_q.size() < rd_idx + n && k < 20000) begin step(1); k++; end
    if (got_q.size() < rd_idx + n) check_eq({tag, "_timeout"}, got_q.size() - rd_idx, n);
    for (int i = 0; i < n; i++)
      if (rd_idx + i < got_q.size()) check_eq({tag, "_byte"}, got_q[rd_idx + i], exp_q[i]);
    rand_ready = 1'b0;
    tx_ready   = 1'b1;
    step(CC + 6);
    check_eq({tag, "_count"}, got_q.size() - rd_idx, n);
    rd_idx = got_q.size();
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int c;
    rst_n       = 1'b0;
    SLOW_OUT    = 1'b1;
    ob          = 5'd0;
    TYPE_STROBE = 1'b0;
    tx_ready    = 1'b0;
    #12;
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_sw_sa", SW_SA, 1);
    check_eq("rst_stop_done", STOP_DONE, 0);
    check_eq("rst_err", ERR, 0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // First-byte latency and hold under backpressure.
    send(26);
    check_eq("lat_t1_valid", tx_valid, 0);
    step(1);
    check_eq("lat_t2_valid", tx_valid, 1);
    check_eq("lat_t2_data", tx_data, 8'h75);
    step(3);
    check_eq("hold_valid", tx_valid, 1);
    check_eq("hold_data", tx_data, 8'h75);
    tx_ready = 1'b1;
    drain("single");

    // Four codes queued back to back, host always ready: exact pacing.
    tx_ready = 1'b1;
    send(16); send(17); send(3); send(25);
    s0 = rd_idx;
    drain("quad");
    for (int i = 0; i < 3; i++)
      if (s0 + i + 1 < got_cyc.size())
        check_eq("quad_gap", got_cyc[s0 + i + 1] - got_cyc[s0 + i], CC + 2);

    // CR with host stalled for 5 clocks.
    tx_ready = 1'b0;
    send(2);
    step(1);
    for (int i = 0; i < 5; i++) begin
      check_eq("cr_hold_valid", tx_valid, 1);
      check_eq("cr_hold_data", tx_data, 8'h0D);
      step(1);
    end
    tx_ready = 1'b1;
    step(1);
    check_eq("lf_valid", tx_valid, 1);
    check_eq("lf_data", tx_data, 8'h0A);
    step(1);
    check_eq("after_lf_valid", tx_valid, 0);
    drain("crlf");

    // STOP then 'z'.
    s0 = stop_cnt;
    exp_stops = 0;
    send(4);
    send(31);
    drain("stop");
    check_eq("stop_pulses", stop_cnt - s0, 1);

    // Randomized traffic: random codes, gaps, SLOW_OUT and host readiness.
    s0 = stop_cnt;
    exp_stops = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      wait_sa();
      SLOW_OUT = ($urandom_range(0, 5) != 0);
      c = $urandom_range(0, 23);
      if (c >= 8) c = c + 8;
      send(c);
      step($urandom_range(0, 3));
    end
    SLOW_OUT = 1'b1;
    drain("rand");
    check_eq("rand_stops", stop_cnt - s0, exp_stops);
    check_eq("rand_err", ERR, 0);

    // Undefined code: sticky ERR, no byte.
    send(9);
    step(5);
    check_eq("undef_err", ERR, 1);
    check_eq("undef_nobyte", got_q.size(), rd_idx);
    step(20);
    check_eq("undef_err_sticky", ERR, 1);

    // Reset while the LF of a CR is being offered, with codes still buffered.
    tx_ready = 1'b0;
    send(2); send(16); send(17);
    step(1);
    check_eq("pre_rst_cr", tx_data, 8'h0D);
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    check_eq("pre_rst_lf", tx_data, 8'h0A);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", tx_valid, 0);
    check_eq("rst_mid_sw_sa", SW_SA, 1);
    check_eq("rst_mid_err", ERR, 0);
    check_eq("rst_mid_data", tx_data, 8'h00);
    step(2);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    step(40);
    check_eq("rst_mid_count", got_q.size() - rd_idx, 1);
    if (rd_idx < got_q.size()) check_eq("rst_mid_cr_byte", got_q[rd_idx], 8'h0D);
    rd_idx = got_q.size();
    exp_q.delete();

    // Six back-to-back strobes with the host stalled: first is popped, four fill, sixth overflows.
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_strobe(16 + i);
      if (i < 5) model_push(16 + i);
      if (i == 3) begin
        check_eq("burst3_sw_sa", SW_SA, 1);
        check_eq("burst3_err", ERR, 0);
      end
      if (i == 4) begin
        check_eq("burst4_sw_sa", SW_SA, 0);
        check_eq("burst4_err", ERR, 0);
      end
    end
    TYPE_STROBE = 1'b0;
    check_eq("burst_sw_sa", SW_SA, 0);
    check_eq("burst_err", ERR, 1);
    tx_ready = 1'b1;
    drain("burst");
    check_eq("burst_sw_sa_end", SW_SA, 1);

    check_eq("stop_single_pulse", stop_dbl, 0);
    check_eq("tx_data_stable", stab_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
